// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: drives the PC register, issues single-outstanding
// imem requests and buffers one word for decode. Define FETCH_PERF_EN for fetch/kill counters.
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [31:0] pc_next,
    output logic        pc_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] kill_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        kill_q, kill_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] fetch_addr;
    logic [31:0] redirect_pc;

    assign fetch_addr  = pc & ~32'h3;
    assign redirect_pc = redirect_target & ~32'h3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // kill marks the outstanding response as stale after a redirect.
    always_comb begin
        state_d    = state_q;
        kill_d     = kill_q;
        req_pc_d   = req_pc_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_gnt) begin
                    req_pc_d = fetch_addr;
                    state_d  = S_WAIT;
                    if (redirect_valid) kill_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (kill_q || redirect_valid) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        if_instr_d = imem_rdata;
                        if_pc_d    = req_pc_q;
                        state_d    = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    kill_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid || if_ready) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kill_q     <= 1'b0;
            req_pc_q   <= 32'h0;
            if_pc_q    <= 32'h0;
            if_instr_q <= 32'h0;
        end else begin
            kill_q     <= kill_d;
            req_pc_q   <= req_pc_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

    // Redirect wins over everything; otherwise the PC only moves on a decode accept.
    always_comb begin
        imem_req  = (state_q == S_REQ);
        imem_addr = fetch_addr;
        if_valid  = (state_q == S_HOLD) && !redirect_valid;
        if_pc     = if_pc_q;
        if_instr  = if_instr_q;
        pc_stall  = 1'b1;
        pc_next   = (state_q == S_IDLE) ? RESET_PC : pc;
        if (redirect_valid) begin
            pc_stall = 1'b0;
            pc_next  = redirect_pc;
        end else if (state_q == S_HOLD && if_ready) begin
            pc_stall = 1'b0;
            pc_next  = pc + 32'd4;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] kill_cnt_q, kill_cnt_d;
    logic        accept, discard;

    assign accept  = (state_q == S_HOLD) && !redirect_valid && if_ready;
    assign discard = (state_q == S_WAIT) && imem_rvalid && (kill_q || redirect_valid);

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        kill_cnt_d  = kill_cnt_q;
        if (accept)  fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (discard) kill_cnt_d  = kill_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= 32'h0;
            kill_cnt_q  <= 32'h0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign kill_cnt  = kill_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: PC register and imem models, scoreboard of expected
// decode transfers filled when the memory model returns a word.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        pc_stall;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] kill_cnt;
`endif

    fetch_controller dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_next(pc_next), .pc_stall(pc_stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr)
`ifdef FETCH_PERF_EN
        , .fetch_cnt(fetch_cnt), .kill_cnt(kill_cnt)
`endif
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc <= 32'h0;
        else if (!pc_stall) pc <= pc_next;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] gnt_log[$];
    int          total = 0;
    int          bad = 0;
    bit          pending = 0, model_kill = 0, drop_pending = 0, resp_pushed_now = 0;
    bit          granted_now = 0, xfer_now = 0, saw_dead = 0;
    bit          fixed_en = 1, ovr_en = 0;
    logic [31:0] ovr_data = 32'h0, mem_addr = 32'h0, last_gnt = 32'h0;
    int          mem_cnt = 0, rvalid_lat = 1, exp_kills = 0, exp_fetches = 0;

    // Negedge half: observe transfers, redirects and grants.
    task automatic half_a();
        exp_t e;
        @(negedge clk);
        granted_now = 0;
        xfer_now    = 0;
        if (rst) begin
            sb.delete();
            model_kill = 0;
            if (pending) drop_pending = 1;
            exp_kills   = 0;
            exp_fetches = 0;
            return;
        end
        if (if_valid && if_ready) begin
            xfer_now = 1;
            exp_fetches++;
            total++;
            if (if_instr === 32'hDEAD_BEEF) saw_dead = 1;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL xfer_unexpected: got pc=%h instr=%h, required no transfer", if_pc, if_instr);
            end else begin
                e = sb.pop_front();
                if (if_pc !== e.pc || if_instr !== e.instr) begin
                    bad++;
                    $display("FAIL xfer_data: got pc=%h instr=%h, required pc=%h instr=%h",
                             if_pc, if_instr, e.pc, e.instr);
                end
            end
        end
        if (redirect_valid) begin
            if (imem_rvalid && resp_pushed_now) begin
                void'(sb.pop_back());
                exp_kills++;
            end else if (!imem_rvalid && sb.size() > 0) begin
                void'(sb.pop_front());
            end else if (pending || (imem_req && imem_gnt)) begin
                model_kill = 1;
            end
        end
        if (imem_req && imem_gnt) begin
            granted_now = 1;
            last_gnt    = imem_addr;
            gnt_log.push_back(imem_addr);
            pending  = 1;
            mem_cnt  = rvalid_lat;
            mem_addr = imem_addr;
        end
    endtask

    // Posedge half: drive the memory response for the new cycle.
    task automatic half_b();
        @(posedge clk);
        #1;
        redirect_valid  = 0;
        imem_rvalid     = 0;
        imem_rdata      = 32'hFFFF_FFFF;
        resp_pushed_now = 0;
        if (pending) begin
            mem_cnt--;
            if (mem_cnt <= 0) begin
                pending     = 0;
                imem_rvalid = 1;
                if (ovr_en) begin
                    imem_rdata = ovr_data;
                    ovr_en     = 0;
                end else begin
                    imem_rdata = fixed_en ? 32'h0000_0013 : (mem_addr ^ 32'h5A5A_0000);
                end
                if (drop_pending) drop_pending = 0;
                else if (model_kill) begin
                    model_kill = 0;
                    exp_kills++;
                end else begin
                    sb.push_back('{pc: mem_addr, instr: imem_rdata});
                    resp_pushed_now = 1;
                end
            end
        end
    endtask

    task automatic tick();
        half_a();
        half_b();
    endtask

    task automatic wait_grant(input string nm);
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            half_a();
            got = granted_now;
            half_b();
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL %s_grant_timeout: no grant in 40 cycles, required a grant", nm);
        end
    endtask

    task automatic wait_xfer(input string nm);
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            half_a();
            got = xfer_now;
            half_b();
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL %s_xfer_timeout: no transfer in 40 cycles, required one", nm);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        tick();
        half_a();
        total += 6;
        if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_imem_req: got %b, required 0", imem_req); end
        if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_if_valid: got %b, required 0", if_valid); end
        if (if_pc !== 32'h0) begin bad++; $display("FAIL reset_if_pc: got %h, required 0", if_pc); end
        if (if_instr !== 32'h0) begin bad++; $display("FAIL reset_if_instr: got %h, required 0", if_instr); end
        if (pc_stall !== 1'b1) begin bad++; $display("FAIL reset_pc_stall: got %b, required 1", pc_stall); end
        if (pc_next !== 32'h0) begin bad++; $display("FAIL reset_pc_next: got %h, required 0", pc_next); end
`ifdef FETCH_PERF_EN
        total++;
        if (fetch_cnt !== 32'h0 || kill_cnt !== 32'h0) begin
            bad++; $display("FAIL reset_cnt: got %h/%h, required 0/0", fetch_cnt, kill_cnt);
        end
`endif
        half_b();
        rst = 0;
    endtask

    task automatic test_stream();
        int vpos[$];
        gnt_log.delete();
        for (int i = 0; i < 10; i++) begin
            half_a();
            if (if_valid) vpos.push_back(i);
            half_b();
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (gnt_log.size() <= k || gnt_log[k] !== 32'(k * 4)) begin
                bad++;
                $display("FAIL stream_addr%0d: got %h, required %h", k,
                         (gnt_log.size() > k) ? gnt_log[k] : 32'hFFFF_FFFF, 32'(k * 4));
            end
        end
        total++;
        if (vpos.size() != 3) begin
            bad++; $display("FAIL stream_valid_count: got %0d, required 3", vpos.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if (vpos[k] != 3 + 3 * k) begin
                    bad++; $display("FAIL stream_valid_pos%0d: got cycle %0d, required %0d", k, vpos[k], 3 + 3 * k);
                end
            end
        end
    endtask

    task automatic test_hold_stall();
        bit got = 0;
        fixed_en = 0;
        if_ready = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            half_a();
            if (if_valid) got = 1;
            else half_b();
        end
        total++;
        if (!got || sb.size() == 0) begin
            bad++; $display("FAIL hold_valid_timeout: got no if_valid, required if_valid");
            if (got) half_b();
        end else begin
            for (int k = 0; k < 5; k++) begin
                total++;
                if (if_valid !== 1'b1 || if_pc !== sb[0].pc || if_instr !== sb[0].instr ||
                    pc_stall !== 1'b1 || imem_req !== 1'b0) begin
                    bad++;
                    $display("FAIL hold_cycle%0d: got v=%b pc=%h instr=%h stall=%b req=%b, required v=1 pc=%h instr=%h stall=1 req=0",
                             k, if_valid, if_pc, if_instr, pc_stall, imem_req, sb[0].pc, sb[0].instr);
                end
                half_b();
                half_a();
            end
            half_b();
        end
        if_ready = 1;
        wait_xfer("hold");
    endtask

    task automatic test_redirect_wait();
        rvalid_lat = 3;
        ovr_en     = 1;
        ovr_data   = 32'hDEAD_BEEF;
        wait_grant("rwait_first");
        redirect_valid  = 1;
        redirect_target = 32'h0000_0100;
        rvalid_lat = 1;
        wait_grant("rwait");
        total++;
        if (last_gnt !== 32'h100) begin bad++; $display("FAIL rwait_addr: got %h, required 00000100", last_gnt); end
        wait_xfer("rwait");
        total++;
        if (saw_dead) begin bad++; $display("FAIL rwait_stale_word: got deadbeef presented, required never presented"); end
`ifdef FETCH_PERF_EN
        total++;
        if (kill_cnt !== 32'd1) begin bad++; $display("FAIL rwait_kill_cnt: got %0d, required 1", kill_cnt); end
`endif
    endtask

    task automatic test_redirect_hold();
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            got = imem_rvalid;
        end
        if (!got) begin total++; bad++; $display("FAIL rhold_timeout: no rvalid, required rvalid"); end
        tick();
        redirect_valid  = 1;
        redirect_target = 32'h0000_0203;
        half_a();
        total += 2;
        if (pc_next !== 32'h200 || pc_stall !== 1'b0) begin
            bad++; $display("FAIL rhold_pc_next: got %h stall=%b, required 00000200 stall=0", pc_next, pc_stall);
        end
        if (if_valid !== 1'b0 || xfer_now) begin
            bad++; $display("FAIL rhold_no_xfer: got if_valid=%b, required 0", if_valid);
        end
        half_b();
        wait_grant("rhold");
        total++;
        if (last_gnt !== 32'h200) begin bad++; $display("FAIL rhold_addr: got %h, required 00000200", last_gnt); end
`ifdef FETCH_PERF_EN
        total++;
        if (fetch_cnt !== 32'(exp_fetches)) begin
            bad++; $display("FAIL rhold_fetch_cnt: got %0d, required %0d", fetch_cnt, exp_fetches);
        end
`endif
        wait_xfer("rhold");
    endtask

    task automatic test_redirect_req();
        bit got = 0;
        imem_gnt = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            half_a();
            got = imem_req;
            half_b();
        end
        if (!got) begin total++; bad++; $display("FAIL rreq_timeout: no imem_req, required imem_req"); end
        redirect_valid  = 1;
        redirect_target = 32'h0000_0040;
        tick();
        tick();
        imem_gnt = 1;
        wait_grant("rreq");
        total++;
        if (last_gnt !== 32'h40) begin bad++; $display("FAIL rreq_addr: got %h, required 00000040", last_gnt); end
        wait_xfer("rreq");
`ifdef FETCH_PERF_EN
        total++;
        if (kill_cnt !== 32'd1) begin bad++; $display("FAIL rreq_kill_cnt: got %0d, required 1", kill_cnt); end
`endif
    endtask

    task automatic test_rst_mid();
        rvalid_lat = 3;
        wait_grant("rst_first");
        tick();
        rst = 1;
        half_a();
        total++;
        if ({imem_req, if_valid, pc_stall, if_pc, if_instr, pc_next} !==
            {1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0}) begin
            bad++;
            $display("FAIL rst_mid_values: got req=%b v=%b stall=%b pc=%h instr=%h next=%h, required 0 0 1 0 0 0",
                     imem_req, if_valid, pc_stall, if_pc, if_instr, pc_next);
        end
`ifdef FETCH_PERF_EN
        total++;
        if (fetch_cnt !== 32'h0 || kill_cnt !== 32'h0) begin
            bad++; $display("FAIL rst_mid_cnt: got %h/%h, required 0/0", fetch_cnt, kill_cnt);
        end
`endif
        half_b();
        rst = 0;
        rvalid_lat = 1;
        wait_grant("rst_restart");
        total++;
        if (last_gnt !== 32'h0) begin bad++; $display("FAIL rst_restart_addr: got %h, required 00000000", last_gnt); end
        wait_xfer("rst_restart");
`ifdef FETCH_PERF_EN
        total++;
        if (fetch_cnt !== 32'd1 || kill_cnt !== 32'd0) begin
            bad++; $display("FAIL rst_restart_cnt: got %0d/%0d, required 1/0", fetch_cnt, kill_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hold_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_redirect_req();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequences instruction fetch around the PC register. It drives that register's `pc_next` and `stall` inputs and issues single-outstanding requests to instruction memory. It buffers the returned word for decode and applies branch/jump redirects, discarding any in-flight fetch made stale by a redirect. It sits between the PC register, the instruction-memory port and the IF/ID stage.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: value `pc_next` presents while idle out of reset. Must match the PC register's reset value.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `pc`  in  32  current PC from the PC register
- `pc_next`  out  32  next PC to the PC register
- `pc_stall`  out  1  hold PC register when 1
- `redirect_valid`  in  1  branch/jump taken this cycle
- `redirect_target`  in  32  redirect address; bits [1:0] forced to 0 internally
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch address, word aligned
- `imem_gnt`  in  1  request accepted this cycle
- `imem_rvalid`  in  1  read data valid
- `imem_rdata`  in  32  instruction word
- `if_valid`  out  1  instruction available to decode
- `if_ready`  in  1  decode accepts
- `if_pc`  out  32  PC of `if_instr`
- `if_instr`  out  32  fetched instruction
- `fetch_cnt`, `kill_cnt`  out  32 each  present only with `FETCH_PERF_EN`

## Operation
- FSM states:
  - IDLE: entered on reset; always goes to REQ next cycle.
  - REQ:
    - `imem_req`=1 and `imem_addr`=`{pc[31:2],2'b00}`.
    - On `imem_gnt`, latch the address into `req_pc` and go to WAIT.
  - WAIT: on `imem_rvalid`:
    - kill clear: register `if_instr`=`imem_rdata` and `if_pc`=`req_pc`, then go to HOLD.
    - kill set: discard the data, clear kill, go to REQ; increment `kill_cnt`.
  - HOLD:
    - `if_valid`=`!redirect_valid`.
    - On `if_valid && if_ready`: `pc_stall`=0, `pc_next`=`pc+4` (mod 2^32), go to REQ; increment `fetch_cnt`.
- Redirect (`redirect_valid`=1) has top priority in every state: `pc_stall`=0 and `pc_next`={`redirect_target[31:2]`,2'b00}.
  - IDLE/REQ without `imem_gnt`: no kill. REQ continues next cycle with the new `pc`. The memory samples the address only on the `imem_gnt` cycle, so the address may change before grant.
  - REQ with `imem_gnt` in the same cycle: go to WAIT with kill set.
  - WAIT: set kill. If `imem_rvalid` arrives in the same cycle, discard that data immediately and go to REQ.
  - HOLD: drop the buffered instruction with no transfer, go to REQ.
- Otherwise `pc_stall`=1 and `pc_next`=`pc`.
- At most one request is outstanding at a time. `imem_rvalid` is ignored outside WAIT.

## Timing
- Reset values:
  - state IDLE, kill 0
  - `imem_req` 0, `if_valid` 0
  - `if_pc` 0, `if_instr` 0, `req_pc` 0
  - `pc_stall` 1, `pc_next` `RESET_PC`
  - counters 0
- `rst` asserted mid-transaction aborts immediately. A late `imem_rvalid` is ignored because the FSM is not in WAIT.
- Best-case cycles per instruction is 3, with `gnt` in the first REQ cycle and `rvalid` one cycle later:
  - REQ (gnt) → WAIT (rvalid) → HOLD (accept) → REQ.
- `imem_rvalid` arrives no earlier than the cycle after `imem_gnt`.
- `pc_next` and `pc_stall` are combinational from state and inputs. The PC register updates on the following edge, and REQ uses the updated `pc`.
- `if_valid`, `if_pc` and `if_instr` are stable while HOLD waits for `if_ready`.

## Configuration
- `FETCH_PERF_EN` defined:
  - `fetch_cnt` counts accepted instructions; `kill_cnt` counts discarded responses.
  - Both are 32-bit, wrap from 0xFFFF_FFFF to 0, and reset to 0.
- `FETCH_PERF_EN` undefined: the counter ports and their logic are absent. All other behaviour is identical.

## Test plan
- Reset, then `gnt`=1 always, `rvalid` one cycle after `gnt`, `rdata`=0x00000013, `if_ready`=1:
  - `imem_addr` sequence 0x0, 0x4, 0x8.
  - `if_valid` one cycle in every 3, `if_pc` 0x0/0x4/0x8.
- `if_ready`=0 for 5 cycles in HOLD:
  - `if_valid`, `if_pc` and `if_instr` held.
  - `pc_stall`=1 throughout; `imem_req`=0.
- Redirect to 0x100 while in WAIT, `rvalid` 2 cycles later with 0xDEADBEEF:
  - the word is never presented; next `imem_addr`=0x100.
  - `kill_cnt`=1.
- Redirect to 0x203 in HOLD with `if_ready`=1 in the same cycle:
  - no transfer and `fetch_cnt` unchanged.
  - `pc_next`=0x200; next request 0x200.
- Redirect to 0x40 in REQ with `gnt` withheld 3 cycles: no kill, the granted address is 0x40, and its data is delivered with `if_pc`=0x40.
- `rst` pulsed while in WAIT, `rvalid` arriving after release:
  - the data is ignored; outputs return to their reset values.
  - fetch restarts at 0x0.
